// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte write strobe and serial line bundle for uart_tx_fifo
interface uart_tx_fifo_if;
    logic [7:0] in;
    logic       clk_in;
    logic       out;
    logic       full;
    logic       empty;
    logic       busy;

    modport master (output in, clk_in, input out, full, empty, busy);
    modport slave  (input in, clk_in, output out, full, empty, busy);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8n1 UART transmitter with a small byte FIFO
module uart_tx_fifo #(
    parameter int o     = 4,
    parameter int depth = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(o);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [depth];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          full_r;
    logic          empty_r;
    logic          wr;
    logic          pop;

    state_t        state;
    state_t        state_n;
    logic [OW-1:0] osc;
    logic [OW-1:0] osc_n;
    logic [2:0]    idx;
    logic [2:0]    idx_n;
    logic [7:0]    sr;
    logic [7:0]    sr_n;
    logic          out_r;
    logic          busy_r;
    logic          last;

    // full is the registered flag, so a write arriving while full is dropped even if a pop coincides
    assign wr   = bus.clk_in & ~full_r;
    assign last = (osc == OW'(o - 1));

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= bus.in;
        end
    end

    always_comb begin
        count_n = count;
        case ({wr, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count   <= count_n;
            full_r  <= (count_n == CW'(depth));
            empty_r <= (count_n == '0);
        end
    end

    always_comb begin
        state_n = state;
        osc_n   = osc;
        idx_n   = idx;
        sr_n    = sr;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_r) begin
                    pop     = 1'b1;
                    sr_n    = mem[rptr];
                    osc_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (last) begin
                    osc_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end else begin
                    osc_n = osc + OW'(1);
                end
            end
            DATA: begin
                if (last) begin
                    osc_n = '0;
                    sr_n  = {1'b0, sr[7:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    osc_n = osc + OW'(1);
                end
            end
            STOP: begin
                if (last) begin
                    osc_n = '0;
                    if (!empty_r) begin
                        pop     = 1'b1;
                        sr_n    = mem[rptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    osc_n = osc + OW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // line level is decoded from the next state so out is a plain flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            osc    <= '0;
            idx    <= '0;
            sr     <= '0;
            out_r  <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            state  <= state_n;
            osc    <= osc_n;
            idx    <= idx_n;
            sr     <= sr_n;
            out_r  <= (state_n == START) ? 1'b0 :
                      (state_n == DATA)  ? sr_n[0] : 1'b1;
            busy_r <= (state_n != IDLE);
        end
    end

    assign bus.out   = out_r;
    assign bus.busy  = busy_r;
    assign bus.full  = full_r;
    assign bus.empty = empty_r;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
    logic clk;
    logic rst_n;
    int   ncmp;
    int   nerr;

    uart_tx_fifo_if bus ();
    uart_tx_fifo_if bus16 ();

    uart_tx_fifo #(.o(4), .depth(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    uart_tx_fifo #(.o(16), .depth(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fbit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    function automatic logic line(input int which);
        return (which != 0) ? bus16.out : bus.out;
    endfunction

    // waits for a start bit, then samples all ten bit centres
    task automatic capture(input int which, output logic [9:0] bits, output bit to);
        int t;
        int per;
        per  = (which != 0) ? 16 : 4;
        to   = 1'b0;
        bits = 'x;
        t    = 0;
        while (line(which) !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            to = 1'b1;
            return;
        end
        t = 0;
        for (int j = 0; j < 10; j++) begin
            while (t < per / 2 + j * per) begin
                @(negedge clk);
                t++;
            end
            bits[j] = line(which);
        end
    endtask

    task automatic do_write(input logic [7:0] d);
        @(negedge clk);
        bus.in     = d;
        bus.clk_in = 1'b1;
        @(negedge clk);
        bus.clk_in = 1'b0;
    endtask

    task automatic test_reset;
        ncmp++; if (bus.out !== 1'b1) begin nerr++; $display("FAIL reset_out got %b want 1", bus.out); end
        ncmp++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        ncmp++; if (bus.full !== 1'b0) begin nerr++; $display("FAIL reset_full got %b want 0", bus.full); end
        ncmp++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_single_frame;
        logic [7:0] d;
        d = 8'hA5;
        do_write(d);
        ncmp++; if (bus.out !== 1'b1) begin nerr++; $display("FAIL single_pre_out got %b want 1", bus.out); end
        ncmp++; if (bus.empty !== 1'b0) begin nerr++; $display("FAIL single_pre_empty got %b want 0", bus.empty); end
        @(negedge clk);
        ncmp++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL single_pop_empty got %b want 1", bus.empty); end
        for (int i = 0; i < 40; i++) begin
            ncmp++; if (bus.out !== fbit(d, i / 4)) begin nerr++; $display("FAIL single_line cyc %0d got %b want %b", i, bus.out, fbit(d, i / 4)); end
            ncmp++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL single_busy cyc %0d got %b want 1", i, bus.busy); end
            @(negedge clk);
        end
        ncmp++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL single_end_busy got %b want 0", bus.busy); end
        ncmp++; if (bus.out !== 1'b1) begin nerr++; $display("FAIL single_end_out got %b want 1", bus.out); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d0;
        logic [7:0] d1;
        d0 = 8'h00;
        d1 = 8'hFF;
        @(negedge clk);
        bus.in = d0; bus.clk_in = 1'b1;
        @(negedge clk);
        bus.in = d1;
        @(negedge clk);
        bus.clk_in = 1'b0;
        for (int i = 0; i < 80; i++) begin
            logic e;
            e = (i < 40) ? fbit(d0, i / 4) : fbit(d1, (i - 40) / 4);
            ncmp++; if (bus.out !== e) begin nerr++; $display("FAIL b2b_line cyc %0d got %b want %b", i, bus.out, e); end
            ncmp++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy cyc %0d got %b want 1", i, bus.busy); end
            @(negedge clk);
        end
        ncmp++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL b2b_end_busy got %b want 0", bus.busy); end
        ncmp++; if (bus.out !== 1'b1) begin nerr++; $display("FAIL b2b_end_out got %b want 1", bus.out); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp [5];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (k == 5) begin
                        ncmp++; if (bus.full !== 1'b1) begin nerr++; $display("FAIL ovf_full_after_55 got %b want 1", bus.full); end
                    end
                    bus.in = 8'((k + 1) * 8'h11);
                    bus.clk_in = 1'b1;
                end
                @(negedge clk);
                bus.clk_in = 1'b0;
                ncmp++; if (bus.full !== 1'b1) begin nerr++; $display("FAIL ovf_full_after_66 got %b want 1", bus.full); end
            end
            begin
                logic [9:0] bits;
                bit to;
                for (int f = 0; f < 5; f++) begin
                    capture(0, bits, to);
                    ncmp++; if (to) begin nerr++; $display("FAIL ovf_timeout frame %0d got none want frame", f); end
                    ncmp++; if (bits !== {1'b1, exp[f], 1'b0}) begin nerr++; $display("FAIL ovf_frame %0d got %h want %h", f, bits, {1'b1, exp[f], 1'b0}); end
                    if (f == 0) begin
                        @(negedge clk);
                        ncmp++; if (bus.full !== 1'b1) begin nerr++; $display("FAIL ovf_full_pre_pop got %b want 1", bus.full); end
                        @(negedge clk);
                        ncmp++; if (bus.full !== 1'b0) begin nerr++; $display("FAIL ovf_full_post_pop got %b want 0", bus.full); end
                    end
                end
            end
        join
        begin
            bit saw_low;
            saw_low = 1'b0;
            repeat (60) begin
                @(negedge clk);
                if (bus.out !== 1'b1) saw_low = 1'b1;
            end
            ncmp++; if (saw_low) begin nerr++; $display("FAIL ovf_extra_frame got low want idle"); end
            ncmp++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL ovf_empty got %b want 1", bus.empty); end
        end
    endtask

    task automatic test_async_reset;
        bit bad;
        @(negedge clk);
        bus.in = 8'hC3; bus.clk_in = 1'b1;
        @(negedge clk);
        bus.in = 8'h12;
        @(negedge clk);
        bus.in = 8'h34;
        @(negedge clk);
        bus.clk_in = 1'b0;
        repeat (16) @(negedge clk);
        ncmp++; if (bus.out !== 1'b0) begin nerr++; $display("FAIL rst_bit3_out got %b want 0", bus.out); end
        ncmp++; if (bus.empty !== 1'b0) begin nerr++; $display("FAIL rst_queued_empty got %b want 0", bus.empty); end
        #2 rst_n = 1'b0;
        #1;
        ncmp++; if (bus.out !== 1'b1) begin nerr++; $display("FAIL rst_async_out got %b want 1", bus.out); end
        ncmp++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rst_async_busy got %b want 0", bus.busy); end
        ncmp++; if (bus.empty !== 1'b1) begin nerr++; $display("FAIL rst_async_empty got %b want 1", bus.empty); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.out !== 1'b1 || bus.busy !== 1'b0) bad = 1'b1;
        end
        ncmp++; if (bad) begin nerr++; $display("FAIL rst_no_frames got activity want idle"); end
    endtask

    task automatic test_loopback;
        logic [7:0] exp [4];
        exp = '{8'h5A, 8'h00, 8'hFF, 8'h81};
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    bus.in = exp[k];
                    bus.clk_in = 1'b1;
                end
                @(negedge clk);
                bus.clk_in = 1'b0;
            end
            begin
                logic [9:0] bits;
                bit to;
                for (int f = 0; f < 4; f++) begin
                    capture(0, bits, to);
                    ncmp++; if (to) begin nerr++; $display("FAIL loop_timeout frame %0d got none want frame", f); end
                    ncmp++; if (bits[8:1] !== exp[f]) begin nerr++; $display("FAIL loop_byte %0d got %h want %h", f, bits[8:1], exp[f]); end
                    ncmp++; if (bits[9] !== 1'b1 || bits[0] !== 1'b0) begin nerr++; $display("FAIL loop_framing %0d got %b%b want 10", f, bits[9], bits[0]); end
                end
            end
        join
        repeat (10) @(negedge clk);
    endtask

    task automatic test_slow_bits;
        fork
            begin
                @(negedge clk);
                bus16.in = 8'h3C;
                bus16.clk_in = 1'b1;
                @(negedge clk);
                bus16.clk_in = 1'b0;
            end
            begin
                logic [9:0] bits;
                bit to;
                capture(1, bits, to);
                ncmp++; if (to) begin nerr++; $display("FAIL o16_timeout got none want frame"); end
                ncmp++; if (bits !== 10'b1_0011_1100_0) begin nerr++; $display("FAIL o16_bits got %b want 1001111000", bits); end
            end
            begin
                int t;
                int n;
                t = 0;
                while (bus16.busy !== 1'b1 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                n = 0;
                while (bus16.busy === 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                ncmp++; if (n != 160) begin nerr++; $display("FAIL o16_frame_len got %0d want 160", n); end
            end
        join
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rst_n = 1'b0;
        bus.in = 8'h00;
        bus.clk_in = 1'b0;
        bus16.in = 8'h00;
        bus16.clk_in = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_single_frame;
        repeat (5) @(negedge clk);
        test_back_to_back;
        repeat (5) @(negedge clk);
        test_overflow;
        test_async_reset;
        test_loopback;
        test_slow_bits;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
